popcount_sched: RTL

POPCOUNT_SCHED -- requirements
Module: popcount_sched

---
 rtl/popcount_pkg.sv | 16 +
 rtl/popcount8.sv | 23 ++
 rtl/popcount_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared constants and FSM encoding for the popcount scheduler.
package popcount_pkg;

   // Width of the operand seen by the shared popcount unit.
   localparam int unsigned DATA_W = 8;
   // Width of a single popcount result (0..8 needs four bits).
   localparam int unsigned CNT_W  = 4;

   // Scheduler phases: waiting for an operand, computing, presenting the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/popcount8.sv
// Combinational 8-bit population count built as a three-level adder tree.
module popcount8
   import popcount_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CNT_W-1:0]  count_o
);

   logic [1:0] pair_sum [4];
   logic [2:0] quad_sum [2];

   // Level 1: neighbouring bits into 2-bit sums; level 2: 3-bit; level 3: final 4-bit.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pair_sum[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
      end
      for (int j = 0; j < 2; j++) begin
         quad_sum[j] = {1'b0, pair_sum[2*j]} + {1'b0, pair_sum[2*j+1]};
      end
      count_o = {1'b0, quad_sum[0]} + {1'b0, quad_sum[1]};
   end

endmodule

// File: rtl/popcount_sched.sv
// Two-requester scheduler sharing one popcount unit, with per-requester
// saturating running totals.
module popcount_sched #(
   parameter int unsigned ACC_W  = 12,
   parameter int unsigned DATA_W = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req0_valid,
   input  logic [DATA_W-1:0]              req0_data,
   output logic                           req0_ready,
   input  logic                           req1_valid,
   input  logic [DATA_W-1:0]              req1_data,
   output logic                           req1_ready,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic                           res_id,
   output logic [popcount_pkg::CNT_W-1:0] res_count,
   input  logic [1:0]                     acc_clr,
   output logic [ACC_W-1:0]               acc0,
   output logic [ACC_W-1:0]               acc1
);

   import popcount_pkg::*;

   // Bits of the operand that reach the popcount unit.
   localparam int unsigned PcW = (DATA_W < popcount_pkg::DATA_W) ? DATA_W : popcount_pkg::DATA_W;

   state_e                  state_q, state_d;
   logic [DATA_W-1:0]       op_q, op_d;
   logic                    id_q, id_d;
   logic                    last_q, last_d;
   logic                    rv_q, rv_d;
   logic                    rid_q, rid_d;
   logic [CNT_W-1:0]        rcnt_q, rcnt_d;
   logic [ACC_W-1:0]        acc0_q, acc0_d;
   logic [ACC_W-1:0]        acc1_q, acc1_d;

   logic                    gnt;
   logic                    idle_ok;
   logic                    hs;
   logic [popcount_pkg::DATA_W-1:0] pc_in;
   logic [CNT_W-1:0]        pc_cnt;
   logic [ACC_W:0]          sum0, sum1;
   logic [ACC_W-1:0]        sat0, sat1;

   // Round-robin choice: a lone valid wins, a tie goes to the requester not served last.
   always_comb begin
      gnt = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt = ~last_q;
      end else if (req1_valid) begin
         gnt = 1'b1;
      end
   end

   // Readies only open in IDLE and never while reset is asserted.
   always_comb begin
      idle_ok    = (state_q == IDLE) && !rst;
      req0_ready = idle_ok && req0_valid && !gnt;
      req1_ready = idle_ok && req1_valid && gnt;
      hs         = req0_ready || req1_ready;
   end

   // Route the latched operand into the 8-bit unit, zero-filling any unused lanes.
   always_comb begin
      pc_in = '0;
      for (int i = 0; i < PcW; i++) begin
         pc_in[i] = op_q[i];
      end
   end

   popcount8 u_popcount8 (
      .data_i  (pc_in),
      .count_o (pc_cnt)
   );

   // Saturating accumulate candidates; the carry out means the total would wrap.
   always_comb begin
      sum0 = {1'b0, acc0_q} + (ACC_W+1)'(pc_cnt);
      sum1 = {1'b0, acc1_q} + (ACC_W+1)'(pc_cnt);
      sat0 = sum0[ACC_W] ? {ACC_W{1'b1}} : sum0[ACC_W-1:0];
      sat1 = sum1[ACC_W] ? {ACC_W{1'b1}} : sum1[ACC_W-1:0];
   end

   // Next-state logic for the FSM, result registers and accumulators.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      id_d    = id_q;
      last_d  = last_q;
      rv_d    = rv_q;
      rid_d   = rid_q;
      rcnt_d  = rcnt_q;
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;

      case (state_q)
         IDLE: begin
            if (hs) begin
               op_d    = gnt ? req1_data : req0_data;
               id_d    = gnt;
               last_d  = gnt;
               state_d = CALC;
            end
         end
         CALC: begin
            rcnt_d  = pc_cnt;
            rid_d   = id_q;
            rv_d    = 1'b1;
            state_d = HOLD;
            if (id_q) begin
               acc1_d = sat1;
            end else begin
               acc0_d = sat0;
            end
         end
         HOLD: begin
            // Returning to IDLE here means the next accept is at least one cycle later.
            if (res_ready) begin
               rv_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            rv_d    = 1'b0;
         end
      endcase

      // A clear overrides any accumulate landing on the same edge.
      if (acc_clr[0]) begin
         acc0_d = '0;
      end
      if (acc_clr[1]) begin
         acc1_d = '0;
      end
   end

   // State register with synchronous reset; reset abandons any in-flight operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         rv_q    <= 1'b0;
         rid_q   <= 1'b0;
         rcnt_q  <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         id_q    <= id_d;
         last_q  <= last_d;
         rv_q    <= rv_d;
         rid_q   <= rid_d;
         rcnt_q  <= rcnt_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
      end
   end

   assign res_valid = rv_q;
   assign res_id    = rid_q;
   assign res_count = rcnt_q;
   assign acc0      = acc0_q;
   assign acc1      = acc1_q;

endmodule
